para_save: RTL and testbench
============================

# para_save

Write-back counterpart of the parameter load path. The MCU pushes 16-bit parameter words through the APB32 mailbox into a local buffer. On a save command the block streams the buffered words to the flash controller as page-sized program bursts, using the same word-request handshake the load path consumes. It sits between the APB32 bridge and the flash controller, parallel to the parameter load block.

## Interface
- DATA_W, 16: parameter word width
- DEPTH, 256: buffer depth in words, power of two
- ADDR_W, 24: flash byte-address width
- PAGE_WORDS, 128: words per program burst (256-byte flash page), power of two, ≤ DEPTH
- i_clk  in  1  sole clock
- i_rst  in  1  reset, synchronous, active-high
- i_apb32bus0  in  32  [31] buffer clear (level), [16] push strobe (rising edge), [15:0] push data
- o_apb32bus0  out  32  [31] busy, [30] full, [29] done (sticky), [28] drop (sticky), [27:17] 0, [16] empty, [15:0] buffered word count
- i_save_start  in  1  one-cycle pulse, start save
- i_base_addr  in  ADDR_W  flash byte address of first word, sampled on i_save_start
- o_flash_wr_start  out  1  one-cycle pulse per burst
- o_flash_addr  out  ADDR_W  burst byte address, held from pulse to i_flash_done
- o_flash_len  out  16  burst length in words, held with o_flash_addr
- i_data_req  in  1  controller requests next word
- o_data  out  DATA_W  word to program
- o_data_vld  out  1  qualifies o_data
- i_flash_done  in  1  one-cycle pulse, burst programmed

## Operation
- Push: rising edge of i_apb32bus0[16] (registered compare) writes [15:0] when state is IDLE and the buffer is not full. Otherwise the word is discarded and drop is set.
- Clear: i_apb32bus0[31]=1 flushes the buffer, clears done and drop, aborts any save, and forces IDLE. No further flash outputs are asserted. An in-flight controller burst is the controller's concern.
- States:
  - IDLE: on i_save_start, latch total=count and addr=i_base_addr, clear done. If total==0, set done and stay in IDLE. Otherwise go to START.
  - START: o_flash_len=min(remaining, PAGE_WORDS). Pulse o_flash_wr_start. Load the burst counter and go to STREAM.
  - STREAM: each i_data_req pops one word. When the burst counter reaches 0, go to WAIT.
  - WAIT: on i_flash_done, addr += 2*len and remaining -= len. If remaining==0, go to FINISH; otherwise go to START.
  - FINISH: set done and go to IDLE.
- Unaligned i_base_addr is not split at the page boundary. The first burst is still PAGE_WORDS long, and page handling belongs to the controller.
- i_data_req outside STREAM, or after the burst counter is exhausted, is ignored: no pop and o_data_vld=0.
- i_flash_done outside WAIT is ignored.
- i_save_start while busy is ignored.
- Pushes during a save are dropped. The buffer content is consumed by the save, so count reads 0 after done.

## Timing
- Reset values: o_data=0, o_data_vld=0, o_flash_wr_start=0, o_flash_addr=0, o_flash_len=0, o_apb32bus0=0x0001_0000 (empty=1), state=IDLE.
- Push: edge on cycle n updates count on n+2 (1 cycle edge register, 1 cycle FIFO write).
- i_save_start on n: o_flash_wr_start on n+1 (START).
- i_data_req on n: o_data/o_data_vld on n+1. Back-to-back requests give back-to-back words, one per cycle.
- Last i_data_req of a burst on n: state is WAIT on n+1.
- i_flash_done on n: next o_flash_wr_start on n+2, or done=1 on n+2.
- busy is 1 from the cycle after i_save_start through FINISH.
- Clear has priority over push, save_start and data_req in the same cycle.

## Structure
- Shared package para_pkg: PARAM_DATA_W, FLASH_ADDR_W, FLASH_PAGE_WORDS, the state enum, and the APB32 status bit indices. The load path reuses the same package.
- Sub-module para_save_fifo: single-clock synchronous FIFO with registered output, plus count, full and empty. Its synchronous clear is driven by i_rst | i_apb32bus0[31].
- The top holds the edge detect, FSM, burst and address counters, and status register.

## Test plan
- Reset, then 3 pushes 0x1111/0x2222/0x3333 -> count=3, empty=0. Save at 0x001000 -> one burst, addr 0x001000, len 3. Words appear in order 1 cycle after each req. done=1, count=0.
- 300 pushes with DEPTH=256 -> count=256, full=1, drop=1. Save at 0x000000 -> bursts (0x000000, 128) and (0x000100, 128). Data matches the first 256 pushed values.
- i_save_start with empty buffer -> no o_flash_wr_start, done=1 within 1 cycle, busy never set.
- i_data_req held high for 5 extra cycles after burst end, and a push mid-burst -> no extra o_data_vld, drop=1, pushed word absent from the stream.
- Clear asserted during STREAM, word 40 of 128 -> IDLE next cycle, count=0, done=0, no further flash outputs. A later i_flash_done is ignored.
- i_rst pulsed mid-WAIT -> all outputs at reset values next cycle. A new push/save sequence then completes normally.

Source files
------------

// File: rtl/para_pkg.sv
// Shared parameter-path package: word/address/page sizes, the save FSM state
// encoding and the APB32 mailbox bit positions. The load path imports it too.
package para_pkg;

    localparam int PARAM_DATA_W     = 16;
    localparam int PARAM_DEPTH      = 256;
    localparam int FLASH_ADDR_W     = 24;
    localparam int FLASH_PAGE_WORDS = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_FINISH
    } para_state_t;

    // i_apb32bus0 fields
    localparam int APB_CLEAR_BIT = 31;
    localparam int APB_PUSH_BIT  = 16;

    // o_apb32bus0 fields
    localparam int APB_BUSY_BIT  = 31;
    localparam int APB_FULL_BIT  = 30;
    localparam int APB_DONE_BIT  = 29;
    localparam int APB_DROP_BIT  = 28;
    localparam int APB_EMPTY_BIT = 16;

endpackage

// File: rtl/para_save_if.sv
// Flash program-burst handshake between para_save (master) and the flash
// controller (slave).
//   wr_start : one-cycle pulse per burst
//   addr/len : burst byte address and word count, held until wr_done
//   data_req : controller asks for the next word
//   data     : word to program, qualified by data_vld one cycle after data_req
//   wr_done  : one-cycle pulse, burst programmed
interface para_save_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 24
);
    logic              wr_start;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len;
    logic              data_req;
    logic [DATA_W-1:0] data;
    logic              data_vld;
    logic              wr_done;

    modport master (
        output wr_start, addr, len, data, data_vld,
        input  data_req, wr_done
    );

    modport slave (
        input  wr_start, addr, len, data, data_vld,
        output data_req, wr_done
    );
endinterface

// File: rtl/para_save_fifo.sv
// Single-clock synchronous FIFO for the parameter save buffer.
//   clk     : clock
//   clr     : synchronous flush (pointers, count, read register)
//   wr_en   : write wr_data when not full
//   rd_en   : pop when not empty; rd_data valid the following cycle
//   count   : words currently held; full / empty flags
module para_save_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/para_save.sv
// Parameter write-back: buffers 16-bit words pushed through the APB32 mailbox
// and streams them to the flash controller as page-sized program bursts.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_apb32bus0      : [31] clear (level), [16] push strobe (edge), [15:0] data
//   o_apb32bus0      : [31] busy [30] full [29] done [28] drop [16] empty [15:0] count
//   i_save_start     : start a save of the whole buffer at i_base_addr
//   flash            : program-burst handshake to the flash controller
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | accepting pushes, waiting for i_save_start
// ST_START  | wr_start pulse, burst counter loaded from len
// ST_STREAM | one buffer word popped per data_req until burst counter is 0
// ST_WAIT   | waiting for wr_done; one extra cycle (reload) to size next burst
// ST_FINISH | set done, back to idle
module para_save
    import para_pkg::*;
#(
    parameter int DATA_W     = PARAM_DATA_W,
    parameter int DEPTH      = PARAM_DEPTH,
    parameter int ADDR_W     = FLASH_ADDR_W,
    parameter int PAGE_WORDS = FLASH_PAGE_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_apb32bus0,
    output logic [31:0]       o_apb32bus0,
    input  logic              i_save_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    para_save_if.master       flash
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    para_state_t       state;
    para_state_t       state_next;
    logic              clear;
    logic              push_q;
    logic              push_evt;
    logic [DATA_W-1:0] push_data;
    logic              fifo_clr;
    logic              fifo_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              pop;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len;
    logic [15:0]       burst_cnt;
    logic              reload;
    logic              done;
    logic              drop;
    logic              data_vld;
    logic              unused_bits;

    function automatic logic [15:0] burst_len(input logic [15:0] words);
        return (words > 16'(PAGE_WORDS)) ? 16'(PAGE_WORDS) : words;
    endfunction

    assign clear       = i_apb32bus0[APB_CLEAR_BIT];
    assign unused_bits = ^i_apb32bus0[30:17];

    // Push strobe edge is registered along with its data, so the FIFO write
    // lands one cycle after the edge is seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            push_q    <= 1'b0;
            push_evt  <= 1'b0;
            push_data <= '0;
        end else begin
            push_q    <= i_apb32bus0[APB_PUSH_BIT];
            push_evt  <= i_apb32bus0[APB_PUSH_BIT] && !push_q;
            push_data <= i_apb32bus0[DATA_W-1:0];
        end
    end

    assign fifo_clr = i_rst || clear;
    assign fifo_wr  = push_evt && !clear && (state == ST_IDLE) && !fifo_full;
    assign pop      = (state == ST_STREAM) && flash.data_req && (burst_cnt != '0) && !clear;

    para_save_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .clr     (fifo_clr),
        .wr_en   (fifo_wr),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (i_save_start && fifo_count != '0) state_next = ST_START;
            ST_START:  state_next = ST_STREAM;
            ST_STREAM: if (pop && burst_cnt == 16'd1) state_next = ST_WAIT;
            ST_WAIT: begin
                if (reload) state_next = ST_START;
                else if (flash.wr_done && 16'(remaining) == len) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            remaining <= '0;
            addr      <= '0;
            len       <= '0;
            burst_cnt <= '0;
            reload    <= 1'b0;
            done      <= 1'b0;
            drop      <= 1'b0;
            data_vld  <= 1'b0;
        end else begin
            data_vld <= pop;
            reload   <= 1'b0;
            if (clear) begin
                done <= 1'b0;
                drop <= 1'b0;
            end else begin
                if (push_evt && (state != ST_IDLE || fifo_full)) drop <= 1'b1;
                unique case (state)
                    ST_IDLE: begin
                        if (i_save_start) begin
                            if (fifo_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                done      <= 1'b0;
                                remaining <= fifo_count;
                                addr      <= i_base_addr;
                                len       <= burst_len(16'(fifo_count));
                            end
                        end
                    end
                    ST_START:  burst_cnt <= len;
                    ST_STREAM: if (pop) burst_cnt <= burst_cnt - 16'd1;
                    ST_WAIT: begin
                        if (reload) begin
                            len <= burst_len(16'(remaining));
                        end else if (flash.wr_done) begin
                            addr      <= addr + ADDR_W'({len, 1'b0});
                            remaining <= remaining - CNT_W'(len);
                            // Non-final burst: spend one cycle sizing the next one.
                            reload    <= (16'(remaining) != len);
                        end
                    end
                    ST_FINISH: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign flash.wr_start = (state == ST_START);
    assign flash.addr     = addr;
    assign flash.len      = len;
    assign flash.data     = fifo_rd_data;
    assign flash.data_vld = data_vld;

    always_comb begin
        o_apb32bus0                = '0;
        o_apb32bus0[15:0]          = 16'(fifo_count);
        o_apb32bus0[APB_BUSY_BIT]  = (state != ST_IDLE);
        o_apb32bus0[APB_FULL_BIT]  = fifo_full;
        o_apb32bus0[APB_DONE_BIT]  = done;
        o_apb32bus0[APB_DROP_BIT]  = drop;
        o_apb32bus0[APB_EMPTY_BIT] = fifo_empty;
    end
endmodule

// File: tb/tb_para_save.sv
module tb_para_save;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] apb_in;
    logic [31:0] apb_out;
    logic        save_start;
    logic [23:0] base_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_data  [$];
    logic [39:0] exp_burst [$];

    para_save_if #(.DATA_W(16), .ADDR_W(24)) fif ();

    para_save dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_apb32bus0  (apb_in),
        .o_apb32bus0  (apb_out),
        .i_save_start (save_start),
        .i_base_addr  (base_addr),
        .flash        (fif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (fif.data_vld === 1'b1) begin
                if (exp_data.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_word: actual %h required none", fif.data);
                end else begin
                    check("data_word", 64'(fif.data), 64'(exp_data.pop_front()));
                end
            end
            if (fif.wr_start === 1'b1) begin
                if (exp_burst.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_burst: actual %h/%0d required none", fif.addr, fif.len);
                end else begin
                    check("burst_addr_len", 64'({fif.addr, fif.len}), 64'(exp_burst.pop_front()));
                end
            end
        end
    end

    task automatic push(input logic [15:0] w);
        apb_in[16]   = 1'b1;
        apb_in[15:0] = w;
        tick();
        apb_in[16] = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        apb_in[31] = 1'b1;
        tick();
        apb_in[31] = 1'b0;
        tick();
    endtask

    task automatic save(input logic [23:0] a);
        save_start = 1'b1;
        base_addr  = a;
        tick();
        save_start = 1'b0;
    endtask

    task automatic wait_burst(output bit ok);
        int k = 0;
        while (fif.wr_start !== 1'b1 && k < 20) begin tick(); k++; end
        ok = (fif.wr_start === 1'b1);
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL burst_start_timeout: actual none required wr_start");
        end
    endtask

    task automatic serve_burst(input int extra, input bit push_mid, input bit send_done);
        bit ok;
        int len;
        wait_burst(ok);
        if (!ok) return;
        len = int'(fif.len);
        tick();
        fif.data_req = 1'b1;
        for (int i = 0; i < len + extra; i++) begin
            if (push_mid && i == 1) begin apb_in[16] = 1'b1; apb_in[15:0] = 16'hDEAD; end
            if (push_mid && i == 2) apb_in[16] = 1'b0;
            tick();
        end
        fif.data_req = 1'b0;
        if (send_done) begin
            tick(); tick();
            fif.wr_done = 1'b1;
            tick();
            fif.wr_done = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (apb_out[29] !== 1'b1 && k < 10) begin tick(); k++; end
    endtask

    task automatic check_drained(input string name);
        check({name, "_data_drained"}, 64'(exp_data.size()), 64'd0);
        check({name, "_burst_drained"}, 64'(exp_burst.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        apb_in       = '0;
        save_start   = 1'b0;
        base_addr    = '0;
        fif.data_req = 1'b0;
        fif.wr_done  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset values
        check("rst_status", 64'(apb_out), 64'h0001_0000);
        check("rst_data", 64'(fif.data), 64'd0);
        check("rst_vld", 64'(fif.data_vld), 64'd0);
        check("rst_wr_start", 64'(fif.wr_start), 64'd0);
        check("rst_addr_len", 64'({fif.addr, fif.len}), 64'd0);

        // three pushes, one short burst
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        check("t1_count", 64'(apb_out), 64'h0000_0003);
        exp_burst.push_back({24'h001000, 16'd3});
        exp_data.push_back(16'h1111);
        exp_data.push_back(16'h2222);
        exp_data.push_back(16'h3333);
        save(24'h001000);
        check("t1_busy", 64'(apb_out[31]), 64'd1);
        serve_burst(0, 1'b0, 1'b1);
        wait_done();
        check("t1_done", 64'(apb_out), 64'h2001_0000);
        check_drained("t1");

        // overfill, two page bursts
        do_clear();
        for (int i = 0; i < 300; i++) push(16'(16'h4000 + i * 3));
        check("t2_full", 64'(apb_out), 64'h5000_0100);
        exp_burst.push_back({24'h000000, 16'd128});
        exp_burst.push_back({24'h000100, 16'd128});
        for (int i = 0; i < 256; i++) exp_data.push_back(16'(16'h4000 + i * 3));
        save(24'h000000);
        serve_burst(0, 1'b0, 1'b1);
        serve_burst(0, 1'b0, 1'b1);
        wait_done();
        check("t2_done", 64'(apb_out), 64'h3001_0000);
        check_drained("t2");

        // save with empty buffer
        do_clear();
        save(24'h123456);
        check("t3_done_1cyc", 64'(apb_out), 64'h2001_0000);
        repeat (3) tick();
        check("t3_idle_after", 64'(apb_out), 64'h2001_0000);

        // extra requests past burst end and a push mid-burst
        do_clear();
        push(16'h0A0A);
        push(16'h0B0B);
        push(16'h0C0C);
        push(16'h0D0D);
        exp_burst.push_back({24'h000200, 16'd4});
        exp_data.push_back(16'h0A0A);
        exp_data.push_back(16'h0B0B);
        exp_data.push_back(16'h0C0C);
        exp_data.push_back(16'h0D0D);
        save(24'h000200);
        serve_burst(5, 1'b1, 1'b1);
        wait_done();
        check("t4_done_drop", 64'(apb_out), 64'h3001_0000);
        check_drained("t4");

        // clear during STREAM after 40 words
        do_clear();
        for (int i = 0; i < 128; i++) push(16'(16'h5A00 + i));
        exp_burst.push_back({24'h004000, 16'd128});
        for (int i = 0; i < 40; i++) exp_data.push_back(16'(16'h5A00 + i));
        save(24'h004000);
        begin
            bit ok;
            wait_burst(ok);
            if (ok) begin
                tick();
                fif.data_req = 1'b1;
                repeat (40) tick();
                apb_in[31] = 1'b1;
                tick();
                check("t5_cleared", 64'(apb_out), 64'h0001_0000);
                check("t5_no_vld", 64'(fif.data_vld), 64'd0);
                apb_in[31]   = 1'b0;
                fif.data_req = 1'b0;
                tick(); tick();
                fif.wr_done = 1'b1;
                tick();
                fif.wr_done = 1'b0;
                repeat (4) tick();
                check("t5_still_idle", 64'(apb_out), 64'h0001_0000);
            end
        end
        check_drained("t5");

        // reset pulse mid-WAIT, then a normal save
        do_clear();
        for (int i = 0; i < 200; i++) push(16'(16'hC000 + i));
        exp_burst.push_back({24'h010000, 16'd128});
        for (int i = 0; i < 128; i++) exp_data.push_back(16'(16'hC000 + i));
        save(24'h010000);
        serve_burst(0, 1'b0, 1'b0);
        tick();
        check("t6_in_wait", 64'(apb_out[31]), 64'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_status", 64'(apb_out), 64'h0001_0000);
        check("t6_rst_addr_len", 64'({fif.addr, fif.len}), 64'd0);
        check("t6_rst_data", 64'({fif.data, fif.data_vld, fif.wr_start}), 64'd0);
        rst = 1'b0;
        tick();
        check_drained("t6a");
        push(16'h7777);
        push(16'h8888);
        exp_burst.push_back({24'h000ABC, 16'd2});
        exp_data.push_back(16'h7777);
        exp_data.push_back(16'h8888);
        save(24'h000ABC);
        serve_burst(0, 1'b0, 1'b1);
        wait_done();
        check("t6_done", 64'(apb_out), 64'h2001_0000);
        check_drained("t6b");

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
